iru_rot_addr_gen: RTL and testbench
===================================

# iru_rot_addr_gen

Rotation address generator for the image rotation unit (IRU). On a start handshake it latches an angle bin, then walks every destination pixel of a DIM×DIM window in raster order. For each pixel it emits the rotated source coordinate and an in-bounds flag through a pipelined valid/ready stream. It sits between the RNN angle classifier and the pixel-fetch stage, and replaces the single-pixel combinational coordinate calculator with a self-sequencing, back-pressurable, parametrised engine.

## Interface
- DIM, 20: window edge length in pixels; must be even, at least 4.
- NUM_ANGLES, 36: angle bins; bin k = k·(360/NUM_ANGLES) degrees.
- TRIG_W, 9: signed width of the cos/sin LUT outputs.
- FRAC, 7: fractional bits of the LUT values; 1.0 = 2^FRAC.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  angle request valid.
- start_ready  output  1  high only in IDLE.
- angle_idx  input  $clog2(NUM_ANGLES)  angle bin; values ≥ NUM_ANGLES are treated as 0.
- out_valid  output  1  coordinate beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_dst_row, out_dst_col  output  $clog2(DIM) each  destination pixel.
- out_src_row, out_src_col  output  $clog2(DIM) each  low bits of the computed source coordinate.
- out_in_bounds  output  1  source lies within [0, DIM) on both axes.
- out_last  output  1  final beat of the frame, dst (DIM-1, DIM-1).
- busy  output  1  high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE to RUN when start_valid && start_ready. The handshake latches the cos and sin values for angle_idx and clears the row and column counters.
  - RUN issues one pixel per advancing cycle. The column wraps at DIM-1 and then increments the row. After issuing (DIM-1, DIM-1) the state goes to DRAIN.
  - DRAIN goes to IDLE in the cycle after the beat with out_last is accepted.
- Arithmetic, with C = DIM/2 and all terms signed:
  - dx = col − C; dy = row − C; each is $clog2(DIM)+1 bits wide.
  - src_col = ((dx·cos − dy·sin) >>> FRAC) + C
  - src_row = ((dx·sin + dy·cos) >>> FRAC) + C
  - The shift is arithmetic, so results floor toward −∞.
  - Intermediate width is TRIG_W + $clog2(DIM) + 3 bits, so there is no overflow.
- out_in_bounds = (0 ≤ src_row < DIM) && (0 ≤ src_col < DIM).
- out_src_row and out_src_col always carry the low bits of the result, whatever the value of out_in_bounds.
- Pipeline:
  - Stage 0: counter issue.
  - Stage 1: the four products are registered, along with dst and last.
  - Stage 2: the sums, shift, bounds compare and output registers.
- The whole pipeline advances on adv = !out_valid || out_ready. Counters and stage registers hold when adv is low.
- start_valid outside IDLE is ignored. No request is queued.
- Reset (asynchronous, at any time, including mid-frame) forces:
  - state to IDLE;
  - counters, latched trig values and stage valid bits to 0;
  - every output to 0 except start_ready, which is 1.
  - The frame in flight is discarded.

## Timing
- The start handshake is at edge 0. Pixel (0,0) issues at edge 1, and its beat has out_valid high after edge 3. First-beat latency is therefore 3 cycles.
- Throughput is 1 beat per cycle while out_ready is held high. An unstalled frame takes DIM² + 3 cycles from handshake to IDLE.
- When out_valid && !out_ready, all outputs hold stable. No beat is dropped or duplicated.
- A new start is accepted at the earliest one cycle after the last beat is accepted.

## Configuration
- IRU_ROT_ROUND_EN:
  - When defined, 2^(FRAC-1) is added to each sum before the >>> FRAC, giving round-half-up.
  - When undefined, the result is truncated (floored) as written above.
- Latency and interface are identical in both builds.

## Structure
- Package iru_pkg holds:
  - the DIM, NUM_ANGLES, TRIG_W and FRAC defaults;
  - the derived widths;
  - the state enum {IDLE, RUN, DRAIN}.
- Sub-module iru_trig_lut is combinational. It maps angle_idx to signed cos and sin values, each equal to round(2^FRAC · trig(angle)). It is parametrised on NUM_ANGLES, TRIG_W and FRAC.

## Test plan
- Angle 0 (cos=128, sin=0), out_ready held high:
  - 400 beats in raster order, each with src = dst and out_in_bounds = 1;
  - out_last only on beat 400;
  - busy falls 403 cycles after the handshake.
- Angle 9 (90°, cos=0, sin=128):
  - dst (0,0) gives src_row=0, src_col=20 (low bits 20), out_in_bounds=0;
  - dst (1,0) gives src (0,19), out_in_bounds=1.
- Angle 1 (cos=126, sin=22), dst (0,10):
  - src (0,11) when IRU_ROT_ROUND_EN is undefined;
  - src (0,12) when it is defined.
- Back-pressure: drop out_ready for 5 cycles at beat 57, and randomise it thereafter. Required result: outputs stable while stalled, exactly 400 beats, no gaps or repeats in the dst sequence.
- Start pulses while busy are ignored. A back-to-back request accepted in the first cycle after DRAIN starts a clean new frame.
- Assert rst at beat 123: all outputs go to 0 immediately with start_ready = 1. A subsequent start produces a full 400-beat frame.

Source files
------------

// File: rtl/iru_pkg.sv
// iru_pkg: shared definitions for the image rotation unit address generator.
//   - default window size, angle-bin count and trig LUT format
//   - widths derived from those defaults
//   - address generator state encoding
//   - real-to-integer rounding helper used when building the trig table
package iru_pkg;

    localparam int IRU_DIM        = 32'd20;
    localparam int IRU_NUM_ANGLES = 32'd36;
    localparam int IRU_TRIG_W     = 32'd9;
    localparam int IRU_FRAC       = 32'd7;

    localparam int IRU_CW = $clog2(IRU_DIM);               // pixel coordinate width
    localparam int IRU_AW = $clog2(IRU_NUM_ANGLES);        // angle index width
    localparam int IRU_DW = IRU_CW + 32'd1;                // signed centred offset width
    localparam int IRU_PW = IRU_TRIG_W + IRU_CW + 32'd3;   // product / sum width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } iru_state_e;

    // Round to nearest, halves away from zero.
    function automatic int iru_round_real(input real v);
        if (v >= 0.0) begin
            return $rtoi(v + 0.5);
        end else begin
            return -$rtoi(0.5 - v);
        end
    endfunction

endpackage

// File: rtl/iru_trig_lut.sv
// iru_trig_lut: combinational cos/sin table indexed by angle bin.
//   Bin k is k*(360/NUM_ANGLES) degrees; each entry is round(2^FRAC * trig).
//   The table is padded to a power of two; padding entries repeat bin 0,
//   so out-of-range indices behave as angle 0.
// Ports:
//   angle_idx  in   angle bin
//   cos_val    out  signed cos, FRAC fractional bits
//   sin_val    out  signed sin, FRAC fractional bits
module iru_trig_lut
    import iru_pkg::*;
#(
    parameter int NUM_ANGLES = IRU_NUM_ANGLES,
    parameter int TRIG_W     = IRU_TRIG_W,
    parameter int FRAC       = IRU_FRAC
) (
    input  logic [$clog2(NUM_ANGLES)-1:0] angle_idx,
    output logic signed [TRIG_W-1:0]      cos_val,
    output logic signed [TRIG_W-1:0]      sin_val
);

    localparam int AW      = $clog2(NUM_ANGLES);
    localparam int TABLE_N = 32'd1 << AW;

    // Constant table entry; bins beyond NUM_ANGLES fold onto bin 0.
    function automatic logic signed [TRIG_W-1:0] trig_entry(input int k, input logic want_sin);
        real ang_rad;
        real v;
        int  kk;
        kk      = (k < NUM_ANGLES) ? k : 32'd0;
        ang_rad = 2.0 * 3.14159265358979 * real'(kk) / real'(NUM_ANGLES);
        if (want_sin) begin
            v = $sin(ang_rad);
        end else begin
            v = $cos(ang_rad);
        end
        return TRIG_W'(iru_round_real(v * real'(32'd1 << FRAC)));
    endfunction

    logic signed [TRIG_W-1:0] cos_tab_s [TABLE_N];
    logic signed [TRIG_W-1:0] sin_tab_s [TABLE_N];

    for (genvar k = 0; k < TABLE_N; k++) begin : g_tab
        assign cos_tab_s[k] = trig_entry(k, 1'b0);
        assign sin_tab_s[k] = trig_entry(k, 1'b1);
    end

    // Table read
    always_comb begin
        cos_val = cos_tab_s[angle_idx];
        sin_val = sin_tab_s[angle_idx];
    end

endmodule

// File: rtl/iru_rot_addr_gen.sv
// iru_rot_addr_gen: rotation address generator.
//   A start handshake latches the cos/sin pair for an angle bin; the engine
//   then walks every destination pixel of a DIM x DIM window in raster order
//   and streams the rotated source coordinate for each one.
//   Pipeline: stage 0 issues the pixel, stage 1 registers the four products,
//   stage 2 forms sums, shifts, bounds-checks and drives the output registers.
//   Everything advances together when the output register is free or drained.
// Build option:
//   IRU_ROT_ROUND_EN  when defined, results round half-up instead of flooring.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_valid/start_ready  angle request handshake (ready only in IDLE)
//   angle_idx                angle bin; bins >= NUM_ANGLES behave as bin 0
//   out_valid/out_ready      coordinate beat handshake
//   out_dst_row/out_dst_col  destination pixel
//   out_src_row/out_src_col  low bits of rotated source coordinate
//   out_in_bounds            source lies inside the window on both axes
//   out_last                 final beat of the frame
//   busy                     engine is not IDLE
module iru_rot_addr_gen
    import iru_pkg::*;
#(
    parameter int DIM        = IRU_DIM,
    parameter int NUM_ANGLES = IRU_NUM_ANGLES,
    parameter int TRIG_W     = IRU_TRIG_W,
    parameter int FRAC       = IRU_FRAC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [$clog2(NUM_ANGLES)-1:0] angle_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DIM)-1:0]        out_dst_row,
    output logic [$clog2(DIM)-1:0]        out_dst_col,
    output logic [$clog2(DIM)-1:0]        out_src_row,
    output logic [$clog2(DIM)-1:0]        out_src_col,
    output logic                          out_in_bounds,
    output logic                          out_last,
    output logic                          busy
);

    localparam int CW = $clog2(DIM);
    localparam int DW = CW + 32'd1;
    localparam int PW = TRIG_W + CW + 32'd3;

    localparam logic [CW-1:0]        MAX_C   = CW'(DIM - 32'd1);
    localparam logic signed [DW-1:0] CTR_DW  = DW'(DIM / 32'd2);
    localparam logic signed [PW-1:0] CTR_PW  = PW'(DIM / 32'd2);
    localparam logic signed [PW-1:0] DIM_PW  = PW'(DIM);
    localparam logic signed [PW-1:0] ZERO_PW = {PW{1'b0}};
    localparam logic signed [PW-1:0] ONE_PW  = {{(PW-1){1'b0}}, 1'b1};
`ifdef IRU_ROT_ROUND_EN
    localparam logic signed [PW-1:0] RND_PW  = ONE_PW <<< (FRAC - 32'd1);
`else
    localparam logic signed [PW-1:0] RND_PW  = ZERO_PW;
`endif

    iru_state_e state_r;
    iru_state_e state_nxt_s;
    logic       start_ready_r;
    logic       busy_r;
    logic       start_ready_nxt_s;
    logic       busy_nxt_s;

    logic adv_s;
    logic start_hs_s;
    logic at_end_s;
    logic last_issue_s;
    logic accept_last_s;

    logic [CW-1:0]            row_r;
    logic [CW-1:0]            col_r;
    logic signed [TRIG_W-1:0] lut_cos_s;
    logic signed [TRIG_W-1:0] lut_sin_s;
    logic signed [TRIG_W-1:0] cos_r;
    logic signed [TRIG_W-1:0] sin_r;

    logic          s0_valid_r;
    logic          s0_last_r;
    logic [CW-1:0] s0_row_r;
    logic [CW-1:0] s0_col_r;

    logic signed [DW-1:0] dx_s;
    logic signed [DW-1:0] dy_s;
    logic signed [PW-1:0] dx_pw_s;
    logic signed [PW-1:0] dy_pw_s;
    logic signed [PW-1:0] cos_pw_s;
    logic signed [PW-1:0] sin_pw_s;

    logic                 s1_valid_r;
    logic                 s1_last_r;
    logic [CW-1:0]        s1_row_r;
    logic [CW-1:0]        s1_col_r;
    logic signed [PW-1:0] p_xc_r;
    logic signed [PW-1:0] p_ys_r;
    logic signed [PW-1:0] p_xs_r;
    logic signed [PW-1:0] p_yc_r;

    logic signed [PW-1:0] src_col_s;
    logic signed [PW-1:0] src_row_s;
    logic                 in_bounds_s;

    logic          out_valid_r;
    logic [CW-1:0] out_dst_row_r;
    logic [CW-1:0] out_dst_col_r;
    logic [CW-1:0] out_src_row_r;
    logic [CW-1:0] out_src_col_r;
    logic          out_in_bounds_r;
    logic          out_last_r;

    iru_trig_lut #(
        .NUM_ANGLES (NUM_ANGLES),
        .TRIG_W     (TRIG_W),
        .FRAC       (FRAC)
    ) u_trig_lut (
        .angle_idx (angle_idx),
        .cos_val   (lut_cos_s),
        .sin_val   (lut_sin_s)
    );

    // Handshake and pipeline-advance qualifiers
    always_comb begin
        adv_s         = !out_valid_r || out_ready;
        start_hs_s    = start_valid && start_ready_r;
        at_end_s      = (row_r == MAX_C) && (col_r == MAX_C);
        last_issue_s  = (state_r == RUN) && adv_s && at_end_s;
        accept_last_s = out_valid_r && out_ready && out_last_r;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_hs_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_issue_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (accept_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs, computed for the next state so they can be registered
    always_comb begin
        start_ready_nxt_s = 1'b0;
        busy_nxt_s        = 1'b1;
        case (state_nxt_s)
            IDLE: begin
                start_ready_nxt_s = 1'b1;
                busy_nxt_s        = 1'b0;
            end
            RUN, DRAIN: begin
                start_ready_nxt_s = 1'b0;
                busy_nxt_s        = 1'b1;
            end
            default: begin
                start_ready_nxt_s = 1'b1;
                busy_nxt_s        = 1'b0;
            end
        endcase
    end

    // FSM state and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            start_ready_r <= start_ready_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

    // Raster counters and latched trig pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r <= {CW{1'b0}};
            col_r <= {CW{1'b0}};
            cos_r <= {TRIG_W{1'b0}};
            sin_r <= {TRIG_W{1'b0}};
        end else if (start_hs_s) begin
            row_r <= {CW{1'b0}};
            col_r <= {CW{1'b0}};
            cos_r <= lut_cos_s;
            sin_r <= lut_sin_s;
        end else if ((state_r == RUN) && adv_s) begin
            if (col_r == MAX_C) begin
                col_r <= {CW{1'b0}};
                row_r <= (row_r == MAX_C) ? {CW{1'b0}} : row_r + CW'(1'b1);
            end else begin
                col_r <= col_r + CW'(1'b1);
            end
        end
    end

    // Stage 0: issue the current pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_r <= 1'b0;
            s0_last_r  <= 1'b0;
            s0_row_r   <= {CW{1'b0}};
            s0_col_r   <= {CW{1'b0}};
        end else if (adv_s) begin
            s0_valid_r <= (state_r == RUN);
            s0_last_r  <= (state_r == RUN) && at_end_s;
            s0_row_r   <= row_r;
            s0_col_r   <= col_r;
        end
    end

    // Centred offsets, sign-extended to the product width
    always_comb begin
        dx_s     = $signed({1'b0, s0_col_r}) - CTR_DW;
        dy_s     = $signed({1'b0, s0_row_r}) - CTR_DW;
        dx_pw_s  = PW'(dx_s);
        dy_pw_s  = PW'(dy_s);
        cos_pw_s = PW'(cos_r);
        sin_pw_s = PW'(sin_r);
    end

    // Stage 1: register the four rotation products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_row_r   <= {CW{1'b0}};
            s1_col_r   <= {CW{1'b0}};
            p_xc_r     <= ZERO_PW;
            p_ys_r     <= ZERO_PW;
            p_xs_r     <= ZERO_PW;
            p_yc_r     <= ZERO_PW;
        end else if (adv_s) begin
            s1_valid_r <= s0_valid_r;
            s1_last_r  <= s0_valid_r && s0_last_r;
            s1_row_r   <= s0_row_r;
            s1_col_r   <= s0_col_r;
            p_xc_r     <= dx_pw_s * cos_pw_s;
            p_ys_r     <= dy_pw_s * sin_pw_s;
            p_xs_r     <= dx_pw_s * sin_pw_s;
            p_yc_r     <= dy_pw_s * cos_pw_s;
        end
    end

    // Sums, fixed-point shift back to pixels (floors toward -inf) and bounds
    always_comb begin
        src_col_s   = ((p_xc_r - p_ys_r + RND_PW) >>> FRAC) + CTR_PW;
        src_row_s   = ((p_xs_r + p_yc_r + RND_PW) >>> FRAC) + CTR_PW;
        in_bounds_s = (src_row_s >= ZERO_PW) && (src_row_s < DIM_PW) &&
                      (src_col_s >= ZERO_PW) && (src_col_s < DIM_PW);
    end

    // Stage 2: output registers, held while a beat waits for out_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r     <= 1'b0;
            out_dst_row_r   <= {CW{1'b0}};
            out_dst_col_r   <= {CW{1'b0}};
            out_src_row_r   <= {CW{1'b0}};
            out_src_col_r   <= {CW{1'b0}};
            out_in_bounds_r <= 1'b0;
            out_last_r      <= 1'b0;
        end else if (adv_s) begin
            out_valid_r     <= s1_valid_r;
            out_dst_row_r   <= s1_row_r;
            out_dst_col_r   <= s1_col_r;
            out_src_row_r   <= src_row_s[CW-1:0];
            out_src_col_r   <= src_col_s[CW-1:0];
            out_in_bounds_r <= in_bounds_s;
            out_last_r      <= s1_valid_r && s1_last_r;
        end
    end

    assign start_ready   = start_ready_r;
    assign busy          = busy_r;
    assign out_valid     = out_valid_r;
    assign out_dst_row   = out_dst_row_r;
    assign out_dst_col   = out_dst_col_r;
    assign out_src_row   = out_src_row_r;
    assign out_src_col   = out_src_col_r;
    assign out_in_bounds = out_in_bounds_r;
    assign out_last      = out_last_r;

endmodule

// File: tb/tb_iru_rot_addr_gen.sv
// tb_iru_rot_addr_gen: self-checking bench for iru_rot_addr_gen.
//   Expected beats come from an integer model of the rotation and are queued
//   at each start; a negedge monitor pops and compares every accepted beat and
//   checks that outputs hold while stalled. A table of hand-derived spot
//   pixels is compared against the captured frame after each run.
module tb_iru_rot_addr_gen;
    import iru_pkg::*;

    localparam int DIM  = 20;
    localparam int CW   = 5;
    localparam int AW   = 6;
    localparam int PK   = 4 * CW + 2;
    localparam int NPIX = DIM * DIM;
`ifdef IRU_ROT_ROUND_EN
    localparam int RND = 64;
`else
    localparam int RND = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [AW-1:0] angle_idx;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_dst_row, out_dst_col, out_src_row, out_src_col;
    logic          out_in_bounds, out_last, busy;
    logic [PK-1:0] cur_beat;

    always #5 clk = ~clk;

    iru_rot_addr_gen dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .angle_idx(angle_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dst_row(out_dst_row), .out_dst_col(out_dst_col),
        .out_src_row(out_src_row), .out_src_col(out_src_col),
        .out_in_bounds(out_in_bounds), .out_last(out_last), .busy(busy)
    );

    assign cur_beat = {out_dst_row, out_dst_col, out_src_row, out_src_col, out_in_bounds, out_last};

    int            checks = 0;
    int            failures = 0;
    logic [PK-1:0] exp_q[$];
    logic [PK-1:0] cap[NPIX];
    bit            cap_v[NPIX];
    int            beat_cnt = 0;
    int            ready_mode = 0;

    typedef struct {
        int ang; int r; int c; int er; int ec; bit inb;
    } spot_t;
    spot_t spots[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int fdiv128(input int a);
        if (a >= 0) return a / 128;
        else return -((-a + 127) / 128);
    endfunction

    function automatic logic [PK-1:0] pack(input int r, input int c, input int er, input int ec, input bit inb);
        bit last;
        last = (r == DIM - 1) && (c == DIM - 1);
        return {r[CW-1:0], c[CW-1:0], er[CW-1:0], ec[CW-1:0], inb, last};
    endfunction

    function automatic logic [PK-1:0] model(input int cv, input int sv, input int r, input int c);
        int dx, dy, er, ec;
        bit inb;
        dx  = c - DIM / 2;
        dy  = r - DIM / 2;
        ec  = fdiv128(dx * cv - dy * sv + RND) + DIM / 2;
        er  = fdiv128(dx * sv + dy * cv + RND) + DIM / 2;
        inb = (er >= 0) && (er < DIM) && (ec >= 0) && (ec < DIM);
        return pack(r, c, er, ec, inb);
    endfunction

    task automatic trig_of(input int ang, output int cv, output int sv);
        case (ang)
            1:       begin cv = 126;  sv = 22;  end
            4:       begin cv = 98;   sv = 82;  end
            9:       begin cv = 0;    sv = 128; end
            18:      begin cv = -128; sv = 0;   end
            default: begin cv = 128;  sv = 0;   end
        endcase
    endtask

    // Monitor: scoreboard compare on accepted beats, stability while stalled
    initial begin : monitor
        bit            stall_prev;
        logic [PK-1:0] stall_val;
        stall_prev = 1'b0;
        stall_val  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("stall_hold", {out_valid, cur_beat}, {1'b1, stall_val});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_extra: beat %0h arrived with nothing expected", cur_beat);
                    end else begin
                        check("sb_beat", cur_beat, exp_q.pop_front());
                    end
                    cap[int'(out_dst_row) * DIM + int'(out_dst_col)]   = cur_beat;
                    cap_v[int'(out_dst_row) * DIM + int'(out_dst_col)] = 1'b1;
                    beat_cnt++;
                end
                stall_prev = out_valid && !out_ready;
                stall_val  = cur_beat;
            end
        end
    end

    // out_ready driver: always high, or a 5-cycle drop at beat 57 then random
    initial begin : ready_drv
        int stall_left;
        bit stalled_once;
        stall_left   = 0;
        stalled_once = 1'b0;
        out_ready    = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                if (!stalled_once && beat_cnt >= 57) begin
                    stalled_once = 1'b1;
                    stall_left   = 5;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else if (stalled_once) begin
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready    = 1'b1;
                stalled_once = 1'b0;
                stall_left   = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Queue the whole frame, then perform the start handshake on the next edge
    task automatic start_frame(input int ang);
        int cv, sv;
        trig_of(ang, cv, sv);
        exp_q.delete();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                exp_q.push_back(model(cv, sv, r, c));
        beat_cnt = 0;
        for (int i = 0; i < NPIX; i++) cap_v[i] = 1'b0;
        angle_idx   = AW'(ang);
        start_valid = 1'b1;
        check("start_ready_idle", start_ready, 1'b1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        angle_idx   = 6'd33;
    endtask

    // Wait for the frame to finish; optionally fire start pulses while busy
    task automatic run_wait(input bit pulse, output int n_first, output int n_idle);
        n_first = -1;
        n_idle  = -1;
        for (int n = 1; n <= 6000; n++) begin
            @(posedge clk);
            #1;
            if (n_first < 0 && out_valid) n_first = n;
            if (!busy) begin
                n_idle = n;
                break;
            end
            if (pulse && n == 50) check("start_ready_busy", start_ready, 1'b0);
            start_valid = pulse && (n == 50 || n == 200 || n == 402);
            angle_idx   = 6'd1;
        end
        start_valid = 1'b0;
        if (n_idle < 0) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy still high after 6000 cycles");
        end
    endtask

    task automatic end_frame(input int ang);
        check("beat_count", beat_cnt, NPIX);
        check("queue_empty", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) begin
            if (spots[i].ang == ang) begin
                if (!cap_v[spots[i].r * DIM + spots[i].c]) begin
                    check("spot_missing", 0, 1);
                end else begin
                    check("spot", cap[spots[i].r * DIM + spots[i].c],
                          pack(spots[i].r, spots[i].c, spots[i].er, spots[i].ec, spots[i].inb));
                end
            end
        end
    endtask

    initial begin : main
        int nf, ni;
        spots[0] = '{0, 0, 0, 0, 0, 1'b1};
        spots[1] = '{0, 19, 19, 19, 19, 1'b1};
        spots[2] = '{9, 0, 0, 0, 20, 1'b0};
        spots[3] = '{9, 1, 0, 0, 19, 1'b1};
        spots[4] = '{1, 0, 10, 0, (RND != 0) ? 12 : 11, 1'b1};
        spots[5] = '{4, 0, 0, (RND != 0) ? 28 : 27, (RND != 0) ? 9 : 8, 1'b0};
        spots[6] = '{18, 0, 0, 20, 20, 1'b0};
        spots[7] = '{40, 5, 7, 5, 7, 1'b1};

        rst         = 1'b1;
        start_valid = 1'b0;
        angle_idx   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {start_ready, busy, out_valid, cur_beat}, {1'b1, 1'b0, 1'b0, {PK{1'b0}}});
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Angle 0, ready high: identity mapping, latency and frame length
        start_frame(0);
        run_wait(1'b0, nf, ni);
        check("a0_first_latency", nf, 3);
        check("a0_idle_cycles", ni, 403);
        end_frame(0);

        // Angle 90 with start pulses while busy (including the DRAIN cycle)
        start_frame(9);
        run_wait(1'b1, nf, ni);
        check("a9_first_latency", nf, 3);
        check("a9_idle_cycles", ni, 403);
        end_frame(9);

        // Back-to-back request in the first IDLE cycle
        start_frame(1);
        run_wait(1'b0, nf, ni);
        check("a1_first_latency", nf, 3);
        check("a1_idle_cycles", ni, 403);
        end_frame(1);

        // Back-pressure: 5-cycle stall at beat 57, random afterwards
        ready_mode = 1;
        start_frame(4);
        run_wait(1'b0, nf, ni);
        check("a4_first_latency", nf, 3);
        end_frame(4);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Out-of-range bin behaves as angle 0
        start_frame(40);
        run_wait(1'b0, nf, ni);
        check("a40_idle_cycles", ni, 403);
        end_frame(40);

        // Reset mid-frame at beat 123, then a clean full frame
        start_frame(18);
        for (int n = 0; n < 1000 && beat_cnt < 123; n++) begin
            @(posedge clk);
            #1;
        end
        check("reached_beat_123", beat_cnt, 123);
        rst = 1'b1;
        #1;
        check("midframe_reset", {start_ready, busy, out_valid, cur_beat}, {1'b1, 1'b0, 1'b0, {PK{1'b0}}});
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_frame(18);
        run_wait(1'b0, nf, ni);
        check("a18_first_latency", nf, 3);
        check("a18_idle_cycles", ni, 403);
        end_frame(18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
